sm3_stream_top: RTL

Parametrised streaming front-end for the SM3 hash engine. It accepts a message of any byte length as a stream of DATA_W-bit words over a valid/ready handshake and assembles 512-bit blocks. It performs SM3 padding, including the two-block tail case, and chains the blocks through the existing compression core using a start/done handshake. The 256-bit digest is returned over a valid/ready handshake. It sits between the APB/DMA data path and the compression core, and replaces fixed-width single-shot padding with backpressured, arbitrary-length operation.

---
 rtl/sm3_stream_if.sv | 40 ++++
 rtl/sm3_stream_top.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/sm3_stream_if.sv
// sm3_stream_if - bundle of every non-clock signal of the SM3 streaming front-end.
//   Message input : i_s_data/i_s_valid/o_s_ready/i_s_last/i_s_bytes, plus i_abort
//   Core side     : o_cf_block/o_cf_v/o_cf_start out, i_cf_done/i_cf_v in
//   Digest output : o_hash/o_hash_valid out, i_hash_ready in
//   Status        : o_busy
// The slave modport is the front-end's view; master is the view of the
// surrounding system (data source, compression core and digest sink).
interface sm3_stream_if #(
  parameter int DATA_W = 32
);
  localparam int BYTES_W = $clog2(DATA_W / 8) + 1;

  logic [DATA_W-1:0]  i_s_data;
  logic               i_s_valid;
  logic               o_s_ready;
  logic               i_s_last;
  logic [BYTES_W-1:0] i_s_bytes;
  logic               i_abort;
  logic [511:0]       o_cf_block;
  logic [255:0]       o_cf_v;
  logic               o_cf_start;
  logic               i_cf_done;
  logic [255:0]       i_cf_v;
  logic [255:0]       o_hash;
  logic               o_hash_valid;
  logic               i_hash_ready;
  logic               o_busy;

  modport slave (
    input  i_s_data, i_s_valid, i_s_last, i_s_bytes, i_abort,
    input  i_cf_done, i_cf_v, i_hash_ready,
    output o_s_ready, o_cf_block, o_cf_v, o_cf_start, o_hash, o_hash_valid, o_busy
  );

  modport master (
    output i_s_data, i_s_valid, i_s_last, i_s_bytes, i_abort,
    output i_cf_done, i_cf_v, i_hash_ready,
    input  o_s_ready, o_cf_block, o_cf_v, o_cf_start, o_hash, o_hash_valid, o_busy
  );
endinterface

// File: rtl/sm3_stream_top.sv
// sm3_stream_top - streaming SM3 front-end.
// Collects an arbitrary-length byte message arriving as big-endian DATA_W-bit
// words, assembles 512-bit blocks, applies SM3 padding (including the case
// where the length field spills into an extra block) and chains the blocks
// through an external compression core. The digest leaves over valid/ready.
// Ports:
//   i_clk   - clock
//   i_rst_n - asynchronous active-low reset
//   bus     - sm3_stream_if.slave carrying stream, core, digest and status signals
module sm3_stream_top #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 61
) (
  input logic         i_clk,
  input logic         i_rst_n,
  sm3_stream_if.slave bus
);
  localparam int WPB    = 512 / DATA_W;
  localparam int BPW    = DATA_W / 8;
  localparam int WIDX_W = (WPB > 1) ? $clog2(WPB) : 1;
  localparam logic [255:0] IV =
    256'h7380166f_4914b2b9_172442d7_da8a0600_a96f30bc_163138aa_e38dee4d_b0fb0e4e;

  typedef enum logic [1:0] {ACCEPT, CMP, PAD, OUT} state_t;

  state_t            state, state_nxt;
  logic [511:0]      block;
  logic [255:0]      v;
  logic [WIDX_W-1:0] widx;
  logic [CNT_W-1:0]  count;
  logic              final_blk, pad_pend, marker_done, discard, start;

  logic              ready, accept, word_full;
  logic [6:0]        step, fill;
  logic [CNT_W-1:0]  count_nxt;
  logic [63:0]       len_nxt, len_cur;
  logic [511:0]      wr_block, tail_block, pad_block;

  // Reset is folded into ready so the source sees no acceptance while held in reset.
  assign ready     = i_rst_n && (state == ACCEPT) && !discard;
  assign accept    = bus.i_s_valid && ready && !bus.i_abort;
  assign word_full = (widx == WIDX_W'(WPB - 1));
  assign step      = bus.i_s_last ? 7'(bus.i_s_bytes) : 7'(BPW);
  assign fill      = 7'(widx) * 7'(BPW) + step;
  assign count_nxt = count + CNT_W'(step);
  assign len_nxt   = 64'({count_nxt, 3'b000});
  assign len_cur   = 64'({count, 3'b000});
  assign pad_block = {(marker_done ? 8'h00 : 8'h80), 440'b0, len_cur};

  // Block buffer with the incoming word dropped in at widx, then the same
  // block with the 0x80 marker, zero fill and (if it fits) the bit length.
  // Every byte past the marker is cleared, which also scrubs stale data
  // left over from the previous block and the don't-care tail of the word.
  always_comb begin
    wr_block = block;
    for (int w = 0; w < WPB; w++) begin
      if (WIDX_W'(w) == widx) wr_block[511 - w*DATA_W -: DATA_W] = bus.i_s_data;
    end
    tail_block = wr_block;
    for (int k = 0; k < 64; k++) begin
      if (7'(k) == fill)     tail_block[511 - 8*k -: 8] = 8'h80;
      else if (7'(k) > fill) tail_block[511 - 8*k -: 8] = 8'h00;
    end
    if (fill <= 7'd55) tail_block[63:0] = len_nxt;
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= ACCEPT;
    else          state <= state_nxt;
  end

  // Next-state logic; abort overrides everything and parks the FSM in ACCEPT.
  always_comb begin
    state_nxt = state;
    if (bus.i_abort) begin
      state_nxt = ACCEPT;
    end else begin
      case (state)
        ACCEPT:  if (accept && (bus.i_s_last || word_full)) state_nxt = CMP;
        CMP:     if (bus.i_cf_done) state_nxt = final_blk ? OUT : (pad_pend ? PAD : ACCEPT);
        PAD:     state_nxt = CMP;
        OUT:     if (bus.i_hash_ready) state_nxt = ACCEPT;
        default: state_nxt = ACCEPT;
      endcase
    end
  end

  // Datapath: block buffer, chaining value, counters and padding flags.
  // discard remembers that the core still owes a completion for a block
  // that was abandoned; that completion is swallowed when it shows up.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      block       <= '0;
      v           <= IV;
      widx        <= '0;
      count       <= '0;
      final_blk   <= 1'b0;
      pad_pend    <= 1'b0;
      marker_done <= 1'b0;
      discard     <= 1'b0;
      start       <= 1'b0;
    end else begin
      start <= (state_nxt == CMP) && (state != CMP);
      if (bus.i_cf_done) discard <= 1'b0;
      if (bus.i_abort) begin
        v           <= IV;
        widx        <= '0;
        count       <= '0;
        final_blk   <= 1'b0;
        pad_pend    <= 1'b0;
        marker_done <= 1'b0;
        if ((state == CMP) && !bus.i_cf_done) discard <= 1'b1;
      end else begin
        case (state)
          ACCEPT: begin
            if (accept) begin
              count <= count_nxt;
              if (bus.i_s_last) begin
                block       <= tail_block;
                final_blk   <= (fill <= 7'd55);
                pad_pend    <= (fill > 7'd55);
                marker_done <= (fill < 7'd64);
              end else begin
                block <= wr_block;
                if (!word_full) widx <= widx + WIDX_W'(1);
              end
            end
          end
          CMP: begin
            if (bus.i_cf_done) begin
              v    <= bus.i_cf_v;
              widx <= '0;
            end
          end
          PAD: begin
            block     <= pad_block;
            final_blk <= 1'b1;
            pad_pend  <= 1'b0;
          end
          OUT: begin
            if (bus.i_hash_ready) begin
              v           <= IV;
              count       <= '0;
              widx        <= '0;
              final_blk   <= 1'b0;
              marker_done <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.o_s_ready    = ready;
  assign bus.o_cf_block   = block;
  assign bus.o_cf_v       = v;
  assign bus.o_cf_start   = start;
  assign bus.o_hash       = (state == OUT) ? v : '0;
  assign bus.o_hash_valid = (state == OUT);
  assign bus.o_busy       = (state != ACCEPT) || (count != '0) || (widx != '0) || discard;
endmodule
